tk1_region_mon: RTL

// - Parametrised memory-region security monitor for the tk1 SoC; generalises the single exec-protect window to NUM_REGIONS ranges.
// - Classifies each CPU bus access (read/write/exec) and checks it against per-region deny bits.
// - Drives a sticky force_trap to the CPU on violation; captures the first violation for FW.
// - Sits next to tk1 on the same 8-bit register bus; FW configures and locks regions before switching to app mode.

---
 rtl/tk1_region_mon.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tk1_region_mon.sv
// tk1_region_mon: NUM_REGIONS address-window access monitor with sticky CPU trap and first-violation capture.
// Optional violation counter enabled by defining TK1_MON_VIOL_CNT_EN.
module tk1_region_mon #(
    parameter int NUM_REGIONS = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_addr,
    output logic        force_trap,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);
    localparam logic [1:0] DISABLED = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] TRAPPED  = 2'd2;

    if (NUM_REGIONS < 1 || NUM_REGIONS > 8 || CNT_WIDTH < 8 || CNT_WIDTH > 32) begin : g_param_err
        $error("tk1_region_mon: parameter out of range");
    end

    logic [1:0]  state;
    logic        trap_en;
    logic        violated;
    logic [31:0] viol_addr;
    logic [2:0]  viol_idx;
    logic [1:0]  viol_type;
    logic [31:0] first_q [NUM_REGIONS];
    logic [31:0] last_q  [NUM_REGIONS];
    logic [2:0]  perm_q  [NUM_REGIONS];
    logic        lock_q  [NUM_REGIONS];

    logic        reg_wr;
    logic [7:0]  roff;
    logic        region_sel;
    logic [1:0]  acc_type;
    logic        hit;
    logic [2:0]  hit_idx;
    logic        viol;
    logic [31:0] cnt_rd;
    logic [31:0] rd;

    assign reg_wr     = cs & we;
    assign roff       = address - 8'h10;
    assign region_sel = (address >= 8'h10) && (roff < 8'(4 * NUM_REGIONS));
    assign acc_type   = cpu_instr ? 2'd2 : (|cpu_wstrb ? 2'd1 : 2'd0);
    assign force_trap = state == TRAPPED;
    assign ready      = cs;

    // Scan high to low so the lowest matching region index is the one reported.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if (cpu_addr >= first_q[i] && cpu_addr <= last_q[i] && perm_q[i][acc_type]) begin
                hit     = 1'b1;
                hit_idx = i[2:0];
            end
    end

    assign viol = cpu_valid & (state != DISABLED) & hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= DISABLED;
            trap_en   <= 1'b0;
            violated  <= 1'b0;
            viol_addr <= '0;
            viol_idx  <= '0;
            viol_type <= '0;
        end else begin
            if (reg_wr && address == 8'h00) trap_en <= trap_en | write_data[1];
            if (state == DISABLED && reg_wr && address == 8'h00 && write_data[0]) state <= ARMED;
            else if (state == ARMED && viol && trap_en) state <= TRAPPED;
            if (viol && !violated) begin
                violated  <= 1'b1;
                viol_addr <= cpu_addr;
                viol_idx  <= hit_idx;
                viol_type <= acc_type;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                first_q[i] <= '0;
                last_q[i]  <= '0;
                perm_q[i]  <= '0;
                lock_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_REGIONS; i++)
                if (reg_wr && region_sel && roff[4:2] == i[2:0]) begin
                    if (!lock_q[i] && roff[1:0] == 2'd0) first_q[i] <= write_data;
                    if (!lock_q[i] && roff[1:0] == 2'd1) last_q[i]  <= write_data;
                    if (!lock_q[i] && roff[1:0] == 2'd2) perm_q[i]  <= write_data[2:0];
                    if (roff[1:0] == 2'd3) lock_q[i] <= lock_q[i] | write_data[0];
                end
        end
    end

`ifdef TK1_MON_VIOL_CNT_EN
    logic [CNT_WIDTH-1:0] cnt;
    logic                 cnt_clr;
    assign cnt_clr = reg_wr && address == 8'h03;
    // A clear coinciding with a violation still counts that violation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (viol) cnt <= cnt_clr ? CNT_WIDTH'(1) : (&cnt ? cnt : cnt + 1'b1);
        else if (cnt_clr) cnt <= '0;
    end
    assign cnt_rd = 32'(cnt);
`else
    assign cnt_rd = '0;
`endif

    always_comb begin
        rd = '0;
        if (address == 8'h00) rd = {30'd0, trap_en, state != DISABLED};
        if (address == 8'h01) rd = {22'd0, viol_type, 1'b0, viol_idx, 2'd0, state == TRAPPED, violated};
        if (address == 8'h02) rd = viol_addr;
        if (address == 8'h03) rd = cnt_rd;
        for (int i = 0; i < NUM_REGIONS; i++)
            if (region_sel && roff[4:2] == i[2:0])
                rd = roff[1:0] == 2'd0 ? first_q[i] :
                     roff[1:0] == 2'd1 ? last_q[i] :
                     roff[1:0] == 2'd2 ? {29'd0, perm_q[i]} : {31'd0, lock_q[i]};
    end

    assign read_data = (cs && !we) ? rd : 32'd0;
endmodule
